// File: rtl/hazard_md_ctrl.sv
// Hazard detection and HI/LO multiply/divide sequencing for a 5-stage pipeline.
// Raises stall/E_flush on operand or HI/LO conflicts and counts stalled cycles.
module hazard_md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_md_use,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_op,
    output logic        stall,
    output logic        E_flush,
    output logic        md_busy,
    output logic [3:0]  md_cnt,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_rs, stall_rt, stall_md, busy;

    // A source operand hazards when a younger-needed value is still in flight; r0 never does.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        src_hazard = (tuse != 2'd3) && (src != 5'd0) &&
                     (((src == e_wa) && (tuse < e_tnew)) ||
                      ((src == m_wa) && (tuse < m_tnew)));
    endfunction

    // Combinational hazard evaluation and stall generation.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        stall_rs = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
        stall_rt = src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
        stall_md = D_md_use && (busy || E_md_start);
    end

    assign stall        = stall_rs || stall_rt || stall_md;
    assign E_flush      = stall;
    assign md_busy      = busy;
    assign md_cnt       = cnt_q;
    assign md_done      = done_q;
    assign stall_cycles = stall_cnt_q;

    // Next-state logic for the HI/LO unit sequencer and the stall counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (E_md_start) begin
                    if (E_md_op) begin
                        state_d = ST_DIV;
                        cnt_d   = 4'd10;
                    end else begin
                        state_d = ST_MULT;
                        cnt_d   = 4'd5;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                // Start requests are ignored while an operation is in flight.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            done_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Randomized plus directed bench for hazard_md_ctrl against a counter-based
// reference model of the HI/LO unit and the hazard rules.
module tb_hazard_md_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_md_use, E_md_start, E_md_op;
    logic        stall, E_flush, md_busy, md_done;
    logic [3:0]  md_cnt;
    logic [15:0] stall_cycles;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: remaining busy cycles, done pulse, stall count.
    int rem_m   = 0;
    bit done_m  = 1'b0;
    int sc_m    = 0;

    hazard_md_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_md_use(D_md_use), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_op(E_md_op),
        .stall(stall), .E_flush(E_flush), .md_busy(md_busy), .md_cnt(md_cnt),
        .md_done(md_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_hz(input int r, input int t);
        return (t != 3) && (r != 0) &&
               (((r == int'(E_wa)) && (t < int'(E_tnew))) ||
                ((r == int'(M_wa)) && (t < int'(M_tnew))));
    endfunction

    function automatic bit ref_stall();
        return ref_hz(int'(D_rs), int'(D_tuse_rs)) || ref_hz(int'(D_rt), int'(D_tuse_rt)) ||
               (D_md_use && ((rem_m > 0) || E_md_start));
    endfunction

    // Called just after a negedge with inputs set; returns just after the next negedge.
    task automatic cycle_chk(input bit do_chk);
        bit exp_stall;
        #1;
        exp_stall = ref_stall();
        if (do_chk) begin
            check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
            check_val("e_flush", {31'd0, E_flush}, {31'd0, exp_stall});
            check_val("busy_pre", {31'd0, md_busy}, {31'd0, rem_m > 0});
        end
        @(posedge clk);
        if (!reset) begin
            rem_m  = 0;
            done_m = 1'b0;
            sc_m   = 0;
        end else begin
            if (exp_stall && sc_m < 65535) sc_m++;
            done_m = 1'b0;
            if (rem_m > 0) begin
                if (rem_m == 1) done_m = 1'b1;
                rem_m--;
            end else if (E_md_start) begin
                rem_m = E_md_op ? 10 : 5;
            end
        end
        #1;
        if (do_chk) begin
            check_val("md_cnt", {28'd0, md_cnt}, rem_m);
            check_val("md_done", {31'd0, md_done}, {31'd0, done_m});
            check_val("md_busy", {31'd0, md_busy}, {31'd0, rem_m > 0});
            check_val("excl", {31'd0, md_done & md_busy}, 32'd0);
            check_val("stall_cycles", {16'd0, stall_cycles}, sc_m);
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        reset = 1'b1; D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_md_use = 1'b0; E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_op = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle_chk(1'b1);
        reset = 1'b1;
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b0;
        cycle_chk(1'b0);
        cycle_chk(1'b1);
        reset = 1'b1;
        check_val("rst_cnt", {28'd0, md_cnt}, 32'd0);
        check_val("rst_sc", {16'd0, stall_cycles}, 32'd0);

        // Multiply: 5 busy cycles then a done pulse.
        E_md_start = 1'b1; E_md_op = 1'b0;
        cycle_chk(1'b1);
        check_val("mult_cnt0", {28'd0, md_cnt}, 32'd5);
        E_md_start = 1'b0;
        for (int i = 0; i < 7; i++) cycle_chk(1'b1);

        // Divide with HI/LO consumer waiting: start cycle plus 10 busy cycles stalled.
        do_reset();
        D_md_use = 1'b1; E_md_start = 1'b1; E_md_op = 1'b1;
        cycle_chk(1'b1);
        E_md_start = 1'b0;
        for (int i = 0; i < 10; i++) cycle_chk(1'b1);
        D_md_use = 1'b0;
        cycle_chk(1'b1);
        check_val("div_stall_cnt", {16'd0, stall_cycles}, 32'd11);

        // Operand hazards.
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        #1 check_val("rs_hz", {31'd0, stall}, 32'd1);
        cycle_chk(1'b1);
        D_rs = 5'd0;
        #1 check_val("rs_zero", {31'd0, stall}, 32'd0);
        cycle_chk(1'b1);
        D_rs = 5'd8; D_tuse_rs = 2'd3;
        #1 check_val("rs_unused", {31'd0, stall}, 32'd0);
        cycle_chk(1'b1);
        quiet_inputs();
        D_rt = 5'd9; D_tuse_rt = 2'd1; M_wa = 5'd9; M_tnew = 2'd1;
        #1 check_val("rt_ok", {31'd0, stall}, 32'd0);
        cycle_chk(1'b1);
        M_tnew = 2'd2;
        #1 check_val("rt_hz", {31'd0, stall}, 32'd1);
        cycle_chk(1'b1);

        // Reset aborts a divide at md_cnt==4 with no done pulse.
        quiet_inputs();
        E_md_start = 1'b1; E_md_op = 1'b1;
        cycle_chk(1'b1);
        E_md_start = 1'b0;
        for (int i = 0; i < 6; i++) cycle_chk(1'b1);
        check_val("abort_cnt4", {28'd0, md_cnt}, 32'd4);
        do_reset();
        check_val("abort_busy", {31'd0, md_busy}, 32'd0);
        check_val("abort_cnt", {28'd0, md_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle_chk(1'b1);
            check_val("abort_nodone", {31'd0, md_done}, 32'd0);
        end

        // Saturation of the stall counter.
        D_rs = 5'd8; D_tuse_rs = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        for (int i = 0; i < 65540; i++) cycle_chk(i > 65530);
        check_val("sc_sat", {16'd0, stall_cycles}, 32'h0000FFFF);

        // Start pulses during MULT must not disturb the countdown.
        quiet_inputs();
        E_md_start = 1'b1; E_md_op = 1'b0;
        cycle_chk(1'b1);
        E_md_op = 1'b1;
        cycle_chk(1'b1);
        check_val("mult_ign", {28'd0, md_cnt}, 32'd4);
        E_md_start = 1'b0;
        cycle_chk(1'b1);
        E_md_start = 1'b1;
        cycle_chk(1'b1);
        check_val("mult_ign2", {28'd0, md_cnt}, 32'd2);
        E_md_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle_chk(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 59) != 0);
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            E_wa       = 5'($urandom_range(0, 3));
            M_wa       = 5'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 3));
            M_tnew     = 2'($urandom_range(0, 3));
            D_md_use   = ($urandom_range(0, 3) == 0);
            E_md_start = ($urandom_range(0, 4) == 0);
            E_md_op    = 1'($urandom_range(0, 1));
            cycle_chk(1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
